apu_dmc_reader: RTL
===================

Name: apu_dmc_reader

Overview:
- APU delta-modulation channel (DMC): register file for $4010-$4013 plus the $4015 enable bit, sample memory reader, one-byte sample buffer, rate timer, and delta output unit.
- Issues single-byte DMA requests to the 2A03 DMA controller (dmc_trig / dmc_dma_addr) and consumes the returned byte on dmc_ack.
- Sits in the APU beside the pulse/triangle/noise channels; dmc_out feeds the APU mixer.

Parameters:
- ADDR_BASE, 16'hC000, sample start base address.
- ADDR_WRAP, 16'h8000, address the reader jumps to after reading $FFFF.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_clk  in  1  one-clk-wide CPU-cycle enable.
- reg_we  in  1  write strobe for $4010-$4013; honoured only when cpu_clk=1.
- reg_addr  in  2  register select, 0..3 = $4010..$4013.
- reg_wdata  in  8  CPU write data.
- en_we  in  1  $4015 write strobe; honoured only when cpu_clk=1.
- en_bit  in  1  $4015 bit 4.
- dmc_trig  out  1  DMA request, level.
- dmc_dma_addr  out  16  current sample address.
- dmc_ack  in  1  DMA read cycle in progress.
- from_ram  in  8  DMA read data.
- dmc_irq  out  1  DMC interrupt flag.
- dmc_active  out  1  bytes_remaining != 0, reported as $4015 bit 4.
- dmc_out  out  7  output level to the mixer.

Behaviour:
- Reset (async, rst_n=0) values:
  - dmc_trig=0, dmc_irq=0, dmc_out=0.
  - cur_addr=ADDR_BASE, bytes_remaining=0, buffer empty.
  - irq_en=0, loop=0, rate_idx=0, timer=427.
  - bits_remaining=0, silence=1, shift=0.
  - Reset mid-DMA discards the transfer.
- All state updates occur only on clk edges with cpu_clk=1, except the trig/ack handshake described below.
- $4010 write:
  - irq_en=d[7], loop=d[6], rate_idx=d[3:0].
  - If d[7]=0, dmc_irq clears that cycle.
- $4011 write: dmc_out=d[6:0]. This overrides an output-unit update in the same cycle.
- $4012 write: sample_addr = ADDR_BASE + {d,6'b0}.
- $4013 write: sample_len = {d,4'b0} + 1 (12 bits).
- $4015 write:
  - dmc_irq clears.
  - en_bit=0 sets bytes_remaining=0.
  - en_bit=1 with bytes_remaining=0 restarts: cur_addr=sample_addr, bytes_remaining=sample_len.
  - en_bit=1 with bytes_remaining!=0 has no effect.
- Rate table, CPU cycles, NTSC, indexed by rate_idx 0..15: 428 380 340 320 286 254 226 214 190 160 142 128 106 84 72 54.
- Rate timer:
  - Decrements every cpu_clk.
  - At 0 it reloads (table-1) and issues one output clock.
  - A rate_idx change takes effect at the next reload.
- Output clock:
  - If silence=0: shift[0]=1 and dmc_out<=125 gives dmc_out+=2; shift[0]=0 and dmc_out>=2 gives dmc_out-=2; otherwise hold (no wrap).
  - shift>>=1 and bits_remaining-- regardless of silence.
  - If bits_remaining becomes 0 (or was 0), start a new cycle: bits_remaining=8.
  - New cycle with buffer full: shift=buffer, buffer empty, silence=0.
  - New cycle with buffer empty: silence=1.
- Reader request:
  - dmc_trig rises on the cpu_clk edge where buffer is empty, bytes_remaining!=0 and no request is pending.
  - dmc_trig stays high until the first clk where dmc_ack=1, then falls on that clk.
  - A request is never withdrawn, even if $4015 disables the channel.
- Reader capture:
  - Occurs on the clk where dmc_ack=1 and cpu_clk=1 (end of the DMA read cycle).
  - buffer=from_ram, buffer marked full.
  - cur_addr increments; $FFFF wraps to ADDR_WRAP.
  - bytes_remaining decrements.
- Reaching bytes_remaining=0 on capture:
  - loop=1: restart (same as the $4015 restart).
  - Else if irq_en=1: dmc_irq=1.
- Capture with bytes_remaining already 0 (disabled mid-request): buffer is loaded, addr and count are unchanged, no IRQ.
- Same-cycle capture and $4015 write: the capture decrement applies first, then the $4015 write.
- dmc_dma_addr=cur_addr (registered). dmc_active is combinational from bytes_remaining.

Test Plan:
- $4012=$00, $4013=$00, $4015=$10 -> dmc_trig=1, dmc_dma_addr=$C000; ack with from_ram=$FF -> trig drops on first ack clk, dmc_active=0, no IRQ, buffer full.
- $4010=$80, length 1, enable, ack -> dmc_irq=1 after capture; $4015 write -> dmc_irq=0; $4010=$00 also clears.
- $4010=$4F, $4013=$01 (17 bytes) -> 17 fetches, then cur_addr back to $C000, bytes_remaining=17, no IRQ.
- sample_addr=$FFC0, $4013=$04 (65 bytes) -> the 65th fetch address is $8000 after reading $FFFF.
- $4011=$7E, buffer=$FF, rate $F -> dmc_out holds at 126; $4011=$01 then buffer=$00 -> dmc_out holds at 1; output clocks spaced 54 cpu_clk apart.
- Request pending, $4015=$00, then ack -> trig clears on ack, byte buffered, dmc_active=0, no IRQ; rst_n low mid-DMA -> all outputs at reset values immediately.

Source files
------------

// File: rtl/apu_dmc_reader_if.sv
// Register-write, DMA handshake and channel-output bundle for the APU DMC.
// The slave side is the channel itself; master is the CPU/DMA/mixer side.
interface apu_dmc_reader_if;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        en_we;
  logic        en_bit;
  logic        dmc_trig;
  logic [15:0] dmc_dma_addr;
  logic        dmc_ack;
  logic [7:0]  from_ram;
  logic        dmc_irq;
  logic        dmc_active;
  logic [6:0]  dmc_out;

  modport master (
    output reg_we, reg_addr, reg_wdata, en_we, en_bit, dmc_ack, from_ram,
    input  dmc_trig, dmc_dma_addr, dmc_irq, dmc_active, dmc_out
  );

  modport slave (
    input  reg_we, reg_addr, reg_wdata, en_we, en_bit, dmc_ack, from_ram,
    output dmc_trig, dmc_dma_addr, dmc_irq, dmc_active, dmc_out
  );
endinterface

// File: rtl/apu_dmc_reader.sv
// APU delta-modulation channel: $4010-$4013/$4015 registers, single-byte DMA
// sample reader, one-byte buffer, rate timer and 7-bit delta output unit.
module apu_dmc_reader #(
  parameter logic [15:0] ADDR_BASE = 16'hC000,
  parameter logic [15:0] ADDR_WRAP = 16'h8000
) (
  input logic             clk,
  input logic             rst_n,
  input logic             cpu_clk,
  apu_dmc_reader_if.slave bus
);

  logic [15:0] cur_addr;
  logic [11:0] bytes_rem;
  logic [7:0]  sample_addr_d;
  logic [7:0]  sample_len_d;
  logic [7:0]  buffer;
  logic        buf_full;
  logic [7:0]  shift;
  logic [3:0]  bits_rem;
  logic        silence;
  logic        irq_en;
  logic        loop_flag;
  logic [3:0]  rate_idx;
  logic [8:0]  timer;
  logic        trig_q;
  logic        pend;
  logic        irq_q;
  logic [6:0]  out_q;

  logic        wr_ctrl, wr_dac, wr_addr, wr_len, en_wr;
  logic        capture, req_start, tick, new_cycle;
  logic [15:0] sample_addr, next_addr, addr_nx;
  logic [11:0] sample_len, bytes_nx;
  logic        irq_nx;
  logic        unused_bits;

  function automatic logic [8:0] rate_reload(input logic [3:0] idx);
    case (idx)
      4'd0:    rate_reload = 9'd427;
      4'd1:    rate_reload = 9'd379;
      4'd2:    rate_reload = 9'd339;
      4'd3:    rate_reload = 9'd319;
      4'd4:    rate_reload = 9'd285;
      4'd5:    rate_reload = 9'd253;
      4'd6:    rate_reload = 9'd225;
      4'd7:    rate_reload = 9'd213;
      4'd8:    rate_reload = 9'd189;
      4'd9:    rate_reload = 9'd159;
      4'd10:   rate_reload = 9'd141;
      4'd11:   rate_reload = 9'd127;
      4'd12:   rate_reload = 9'd105;
      4'd13:   rate_reload = 9'd83;
      4'd14:   rate_reload = 9'd71;
      default: rate_reload = 9'd53;
    endcase
  endfunction

  assign unused_bits = ^bus.reg_wdata[5:4];

  assign wr_ctrl = bus.reg_we && cpu_clk && (bus.reg_addr == 2'd0);
  assign wr_dac  = bus.reg_we && cpu_clk && (bus.reg_addr == 2'd1);
  assign wr_addr = bus.reg_we && cpu_clk && (bus.reg_addr == 2'd2);
  assign wr_len  = bus.reg_we && cpu_clk && (bus.reg_addr == 2'd3);
  assign en_wr   = bus.en_we && cpu_clk;

  assign sample_addr = ADDR_BASE + {2'b00, sample_addr_d, 6'b000000};
  assign sample_len  = {sample_len_d, 4'b0000} + 12'd1;
  assign next_addr   = (cur_addr == 16'hFFFF) ? ADDR_WRAP : cur_addr + 16'd1;

  // Only a pending request may complete, so an ack seen after reset is ignored.
  assign capture   = bus.dmc_ack && cpu_clk && pend;
  assign req_start = cpu_clk && !buf_full && (bytes_rem != 12'd0) && !pend;
  assign tick      = cpu_clk && (timer == 9'd0);
  assign new_cycle = (bits_rem <= 4'd1);

  // Capture bookkeeping resolves first; a same-cycle $4015 write then wins.
  always_comb begin
    addr_nx  = cur_addr;
    bytes_nx = bytes_rem;
    irq_nx   = irq_q;
    if (capture && (bytes_rem != 12'd0)) begin
      addr_nx  = next_addr;
      bytes_nx = bytes_rem - 12'd1;
      if (bytes_rem == 12'd1) begin
        if (loop_flag) begin
          addr_nx  = sample_addr;
          bytes_nx = sample_len;
        end else if (irq_en) begin
          irq_nx = 1'b1;
        end
      end
    end
    if (wr_ctrl && !bus.reg_wdata[7]) irq_nx = 1'b0;
    if (en_wr) begin
      irq_nx = 1'b0;
      if (!bus.en_bit) begin
        bytes_nx = 12'd0;
      end else if (bytes_nx == 12'd0) begin
        addr_nx  = sample_addr;
        bytes_nx = sample_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr      <= ADDR_BASE;
      bytes_rem     <= 12'd0;
      sample_addr_d <= 8'd0;
      sample_len_d  <= 8'd0;
      buffer        <= 8'd0;
      buf_full      <= 1'b0;
      shift         <= 8'd0;
      bits_rem      <= 4'd0;
      silence       <= 1'b1;
      irq_en        <= 1'b0;
      loop_flag     <= 1'b0;
      rate_idx      <= 4'd0;
      timer         <= 9'd427;
      trig_q        <= 1'b0;
      pend          <= 1'b0;
      irq_q         <= 1'b0;
      out_q         <= 7'd0;
    end else begin
      cur_addr  <= addr_nx;
      bytes_rem <= bytes_nx;
      irq_q     <= irq_nx;

      if (trig_q && bus.dmc_ack) trig_q <= 1'b0;
      else if (req_start)        trig_q <= 1'b1;

      if (capture)        pend <= 1'b0;
      else if (req_start) pend <= 1'b1;

      if (wr_ctrl) begin
        irq_en    <= bus.reg_wdata[7];
        loop_flag <= bus.reg_wdata[6];
        rate_idx  <= bus.reg_wdata[3:0];
      end
      if (wr_addr) sample_addr_d <= bus.reg_wdata;
      if (wr_len)  sample_len_d  <= bus.reg_wdata;

      if (cpu_clk) timer <= (timer == 9'd0) ? rate_reload(rate_idx) : timer - 9'd1;

      if (tick) begin
        if (!silence) begin
          if (shift[0]) begin
            if (out_q <= 7'd125) out_q <= out_q + 7'd2;
          end else if (out_q >= 7'd2) begin
            out_q <= out_q - 7'd2;
          end
        end
        if (new_cycle) begin
          bits_rem <= 4'd8;
          if (buf_full) begin
            shift    <= buffer;
            buf_full <= 1'b0;
            silence  <= 1'b0;
          end else begin
            shift   <= shift >> 1;
            silence <= 1'b1;
          end
        end else begin
          bits_rem <= bits_rem - 4'd1;
          shift    <= shift >> 1;
        end
      end

      // A pending capture implies the buffer was empty, so it never races a drain.
      if (capture) begin
        buffer   <= bus.from_ram;
        buf_full <= 1'b1;
      end

      if (wr_dac) out_q <= bus.reg_wdata[6:0];
    end
  end

  assign bus.dmc_trig     = trig_q;
  assign bus.dmc_dma_addr = cur_addr;
  assign bus.dmc_irq      = irq_q;
  assign bus.dmc_active   = (bytes_rem != 12'd0);
  assign bus.dmc_out      = out_q;

endmodule
